rr_grant_arbiter: RTL

Round-robin arbiter that shares one resource among 8 requesters and drives a one-hot grant vector, which is the select/enable fan-out consumed downstream. It tracks ownership with a small FSM, enforces a one-cycle turnaround gap between owners, and forcibly reclaims the resource from an owner that holds it longer than a programmable limit. It sits between the requesting blocks and the shared resource's one-hot select input.

---
 rtl/arb_pkg.sv | 35 +++
 rtl/onehot_dec.sv | 24 ++
 rtl/rr_grant_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//
// Shared types, sizes and helpers for the round-robin grant arbiter.
//
//   state_t    : ownership FSM encoding (IDLE, GRANT, GAP)
//   N_REQ      : number of requesters (8)
//   IDX_W      : width of a requester index (3)
//   rotate_req : rotates a request vector so that bit j of the result is
//                request (ptr + j) mod N_REQ. This turns the round-robin
//                search into a plain "lowest set bit wins" search.
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Result bit j = r[(p + j) mod N_REQ].
    // Doubling the vector lets a single part-select perform the wrap.
    function automatic logic [N_REQ-1:0] rotate_req(
        input logic [N_REQ-1:0] r,
        input logic [IDX_W-1:0] p
    );
        logic [2*N_REQ-1:0] doubled;
        doubled = {r, r};
        return doubled[p +: N_REQ];
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// -----------------------------------------------------------------------------
// onehot_dec
//
// Combinational binary-to-one-hot decoder (3 -> 8). It feeds the grant
// register of the arbiter. It is a separate module so that other select paths
// can reuse exactly the same decode.
//
// Ports
//   idx    in  IDX_W  binary index
//   onehot out N_REQ  onehot[idx] = 1, all other bits 0
// -----------------------------------------------------------------------------
module onehot_dec
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// -----------------------------------------------------------------------------
// rr_grant_arbiter
//
// Round-robin arbiter sharing one resource among 8 requesters. It drives a
// registered one-hot grant vector that serves as the downstream select/enable.
// Ownership is tracked by a three-state FSM:
//   IDLE  : nobody owns the resource
//   GRANT : one requester owns it, the hold counter runs
//   GAP   : one turnaround cycle with grant = 0 between any two owners
// An owner that keeps the resource for MAX_HOLD cycles is forcibly reclaimed.
// That reclaim is flagged by a one-cycle timeout pulse during the GAP cycle.
//
// Parameters
//   MAX_HOLD : maximum consecutive grant cycles per ownership (2..65535)
//   CNT_W    : hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk        in   1      clock, all state changes on the rising edge
//   rst        in   1      synchronous active-high reset
//   req        in   8      request vector, bit i = requester i wants the resource
//   rel        in   1      the current owner gives the resource back
//                          (sampled only in GRANT). `release` is a reserved
//                          word, so the port is named rel.
//   grant      out  8      registered one-hot grant, zero when nobody owns
//   grant_idx  out  3      registered index of the current or last owner
//   busy       out  1      high exactly while grant is non-zero
//   timeout    out  1      registered one-cycle pulse marking a forced reclaim
//   state_dbg  out  2      current FSM state, for observation only
//
// Handshake: req[i] is a level "valid" held by requester i. grant[i] is its
// "ready". The transfer is the whole interval in which both are high. The
// owner ends the interval by pulsing rel or by dropping req[i]. Either one is
// seen at the next rising edge, and grant drops after that edge. Only
// registered state drives the outputs. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             rel,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout,
    output state_t           state_dbg
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state;
    logic [IDX_W-1:0] ptr;      // highest-priority requester for the next search
    logic [CNT_W-1:0] hold_cnt; // grant cycles already completed by the current owner

    // -------------------------------------------------------------------------
    // Priority search
    // Rotate the requests so that ptr sits at bit 0. Find the lowest set bit,
    // then add ptr back. The 3-bit add wraps naturally mod 8.
    // -------------------------------------------------------------------------
    logic [N_REQ-1:0] req_rot;
    logic [IDX_W-1:0] win_off;
    logic [IDX_W-1:0] win_idx;
    logic [N_REQ-1:0] win_onehot;
    logic             any_req;

    always_comb begin
        req_rot = rotate_req(req, ptr);
        win_off = '0;
        // Scan downward so the lowest set bit is written last and wins.
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_off = IDX_W'(j);
            end
        end
        win_idx = ptr + win_off;
        any_req = |req;
    end

    onehot_dec u_dec (
        .idx    (win_idx),
        .onehot (win_onehot)
    );

    // -------------------------------------------------------------------------
    // End-of-grant conditions, evaluated in GRANT only
    // -------------------------------------------------------------------------
    logic owner_req;
    logic at_limit;
    logic grant_end;
    logic forced;

    always_comb begin
        owner_req = req[grant_idx];
        at_limit  = (hold_cnt == CNT_W'(MAX_HOLD - 1));
        grant_end = rel | ~owner_req | at_limit;
        // A voluntary end takes precedence. If the limit coincides with rel or
        // a dropped request, it is not reported as a reclaim.
        forced    = at_limit & ~rel & owner_req;
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            // timeout is a pulse. Only the forced-reclaim path raises it.
            timeout <= 1'b0;

            case (state)
                IDLE, GAP: begin
                    if (any_req) begin
                        state     <= GRANT;
                        grant_idx <= win_idx;
                        grant     <= win_onehot;
                        busy      <= 1'b1;
                        hold_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end

                GRANT: begin
                    if (grant_end) begin
                        // Always pass through GAP, so grant never moves
                        // straight from one owner to another.
                        state    <= GAP;
                        grant    <= '0;
                        busy     <= 1'b0;
                        ptr      <= grant_idx + IDX_W'(1);
                        hold_cnt <= '0;
                        timeout  <= forced;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a safe, ownerless state.
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
